// File: rtl/dma_timing_control.sv
// dma_timing_control: timing-and-control sequencer for the 4-channel DMA
// controller. It arbitrates DREQ, runs the HRQ/HLDA hold handshake and steps
// each single-word transfer through SI -> S0 -> S1 -> S2 -> S3 -> S4.
//
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   DREQ[CHANNELS]        level-sensitive channel requests
//   HLDA                  hold acknowledge from the CPU
//   ctrlDisable           blocks new arbitration while in SI
//   xferType[2*CHANNELS]  per-channel type: 00/11 verify, 01 write, 10 read
//   tcReached             active channel hit terminal count
//   HRQ, DACK, AEN, ADSTB bus handshake / acknowledge / address control
//   MEMR_N MEMW_N IOR_N IOW_N  active-low bus command strobes
//   EOP_N, intEOP         end-of-process (external / internal)
//   loadAddr, updateCurrentAddressReg, updateCurrentWordCountReg  datapath strobes
//   programCondition      CPU may program registers
//   activeChannel         latched channel index
//
// Optional feature: define ROTATING_PRIORITY_EN for rotating priority; the
// default build uses fixed priority (channel 0 highest).
module dma_timing_control #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CHW      = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [CHANNELS-1:0]   DREQ,
  input  logic                  HLDA,
  input  logic                  ctrlDisable,
  input  logic [2*CHANNELS-1:0] xferType,
  input  logic                  tcReached,
  output logic                  HRQ,
  output logic [CHANNELS-1:0]   DACK,
  output logic                  AEN,
  output logic                  ADSTB,
  output logic                  MEMR_N,
  output logic                  MEMW_N,
  output logic                  IOR_N,
  output logic                  IOW_N,
  output logic                  EOP_N,
  output logic                  intEOP,
  output logic                  loadAddr,
  output logic                  updateCurrentAddressReg,
  output logic                  updateCurrentWordCountReg,
  output logic                  programCondition,
  output logic [CHW-1:0]        activeChannel
);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

  state_t         state, stateNext;
  logic [CHW-1:0] channel, channelNext;
  logic [CHW-1:0] winner;
  logic           anyReq;
  logic [1:0]     typ;
  logic           isRead, isWrite;

`ifdef ROTATING_PRIORITY_EN
  logic [CHW-1:0] prioPtr;
  int unsigned    idx;

  // Search starts at the pointer; the first requesting channel wins.
  always_comb begin
    winner = '0;
    anyReq = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = (int'(prioPtr) + k) % CHANNELS;
      if (!anyReq && DREQ[idx]) begin
        anyReq = 1'b1;
        winner = CHW'(idx);
      end
    end
  end

  // Only a completed S4 rotates; the serviced channel drops to lowest priority.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      prioPtr <= '0;
    else if (state == S4)
      prioPtr <= (channel == CHW'(CHANNELS - 1)) ? '0 : channel + 1'b1;
  end
`else
  always_comb begin
    winner = '0;
    anyReq = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!anyReq && DREQ[k]) begin
        anyReq = 1'b1;
        winner = CHW'(k);
      end
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= SI;
      channel <= '0;
    end else begin
      state   <= stateNext;
      channel <= channelNext;
    end
  end

  always_comb begin
    stateNext   = state;
    channelNext = channel;
    unique case (state)
      SI: if (!ctrlDisable && anyReq) begin
            stateNext   = S0;
            channelNext = winner;
          end
      S0: if (HLDA)                stateNext = S1;
          else if (!DREQ[channel]) stateNext = SI;
      S1: stateNext = HLDA ? S2 : SI;
      S2: stateNext = HLDA ? S3 : SI;
      S3: stateNext = HLDA ? S4 : SI;
      S4: stateNext = SI;
      default: stateNext = SI;
    endcase
  end

  assign typ     = xferType[{channel, 1'b0} +: 2];
  assign isRead  = (typ == 2'b10);
  assign isWrite = (typ == 2'b01);

  always_comb begin
    HRQ                       = 1'b0;
    DACK                      = '0;
    AEN                       = 1'b0;
    ADSTB                     = 1'b0;
    MEMR_N                    = 1'b1;
    MEMW_N                    = 1'b1;
    IOR_N                     = 1'b1;
    IOW_N                     = 1'b1;
    EOP_N                     = 1'b1;
    intEOP                    = 1'b0;
    loadAddr                  = 1'b0;
    updateCurrentAddressReg   = 1'b0;
    updateCurrentWordCountReg = 1'b0;
    unique case (state)
      SI: ;
      S0: HRQ = 1'b1;
      S1: begin
        HRQ      = 1'b1;
        AEN      = 1'b1;
        ADSTB    = 1'b1;
        loadAddr = 1'b1;
      end
      S2: begin
        HRQ    = 1'b1;
        AEN    = 1'b1;
        DACK   = CHANNELS'(1) << channel;
        MEMR_N = !isRead;
        IOR_N  = !isWrite;
      end
      S3: begin
        HRQ    = 1'b1;
        AEN    = 1'b1;
        DACK   = CHANNELS'(1) << channel;
        MEMR_N = !isRead;
        IOR_N  = !isWrite;
        IOW_N  = !isRead;
        MEMW_N = !isWrite;
      end
      S4: begin
        HRQ                       = 1'b1;
        AEN                       = 1'b1;
        DACK                      = CHANNELS'(1) << channel;
        updateCurrentAddressReg   = 1'b1;
        updateCurrentWordCountReg = 1'b1;
        intEOP                    = tcReached;
        EOP_N                     = !tcReached;
      end
      default: ;
    endcase
  end

  assign programCondition = (state == SI) && !HLDA;
  assign activeChannel    = channel;

endmodule

// File: tb/tb_dma_timing_control.sv
module tb_dma_timing_control;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] DREQ = '0;
  logic       HLDA = 1'b0;
  logic       ctrlDisable = 1'b0;
  logic [7:0] xferType = '0;
  logic       tcReached = 1'b0;
  logic       HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N, intEOP;
  logic       loadAddr, updAddr, updWc, programCondition;
  logic [3:0] DACK;
  logic [1:0] activeChannel;

  int assertions = 0;
  int failures   = 0;

  always #5 CLK = ~CLK;

  dma_timing_control #(.CHANNELS(4), .CHW(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA),
    .ctrlDisable(ctrlDisable), .xferType(xferType), .tcReached(tcReached),
    .HRQ(HRQ), .DACK(DACK), .AEN(AEN), .ADSTB(ADSTB),
    .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .EOP_N(EOP_N), .intEOP(intEOP), .loadAddr(loadAddr),
    .updateCurrentAddressReg(updAddr), .updateCurrentWordCountReg(updWc),
    .programCondition(programCondition), .activeChannel(activeChannel)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: step 0 idle, 1 holding for HLDA, 2..5 = the four bus
  // cycles of a transfer (address load, read, read+write, write-back).
  int mStep = 0;
  int mCh   = 0;
  int mPtr  = 0;

  function automatic int pickChannel(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++)
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return 0;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mStep <= 0; mCh <= 0; mPtr <= 0;
    end else if (mStep == 0) begin
      if (!ctrlDisable && DREQ != 0) begin
        mStep <= 1; mCh <= pickChannel(DREQ, mPtr);
      end
    end else if (mStep == 1) begin
      if (HLDA) mStep <= 2;
      else if (!DREQ[mCh]) mStep <= 0;
    end else if (mStep == 5) begin
      mStep <= 0;
`ifdef ROTATING_PRIORITY_EN
      mPtr <= (mCh + 1) % 4;
`endif
    end else begin
      mStep <= HLDA ? mStep + 1 : 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge CLK) begin
    logic [1:0] t;
    logic rd, bothRW;
    t      = xferType[2*mCh +: 2];
    rd     = (mStep == 3 || mStep == 4);
    bothRW = (mStep == 4);
    check("m_HRQ",    HRQ,    32'(mStep >= 1));
    check("m_AEN",    AEN,    32'(mStep >= 2));
    check("m_ADSTB",  ADSTB,  32'(mStep == 2));
    check("m_load",   loadAddr, 32'(mStep == 2));
    check("m_DACK",   DACK,   (mStep >= 3) ? 32'(1 << mCh) : 32'd0);
    check("m_MEMR_N", MEMR_N, 32'(!(rd && t == 2'b10)));
    check("m_IOR_N",  IOR_N,  32'(!(rd && t == 2'b01)));
    check("m_IOW_N",  IOW_N,  32'(!(bothRW && t == 2'b10)));
    check("m_MEMW_N", MEMW_N, 32'(!(bothRW && t == 2'b01)));
    check("m_updA",   updAddr, 32'(mStep == 5));
    check("m_updW",   updWc,   32'(mStep == 5));
    check("m_intEOP", intEOP,  32'(mStep == 5 && tcReached));
    check("m_EOP_N",  EOP_N,   32'(!(mStep == 5 && tcReached)));
    check("m_prog",   programCondition, 32'(mStep == 0 && !HLDA));
    check("m_chan",   activeChannel, 32'(mCh));
  end

  task automatic nextCycle();
    @(negedge CLK);
  endtask

  // Directed transfer with literal expectations at each bus cycle.
  task automatic xfer(input int ch, input logic [1:0] typ, input logic tc, input logic raiseDis);
    #1; DREQ = 4'(1 << ch); xferType = '0; xferType[2*ch +: 2] = typ; tcReached = tc; HLDA = 1'b0;
    nextCycle();
    check("d_S0_HRQ", HRQ, 1); check("d_S0_AEN", AEN, 0);
    #1; HLDA = 1'b1;
    nextCycle();
    check("d_S1_load", loadAddr, 1); check("d_S1_ADSTB", ADSTB, 1);
    check("d_S1_AEN", AEN, 1); check("d_S1_DACK", DACK, 0);
    if (raiseDis) begin #1; ctrlDisable = 1'b1; end
    nextCycle();
    check("d_S2_DACK", DACK, 32'(1 << ch)); check("d_S2_load", loadAddr, 0);
    check("d_S2_MEMR_N", MEMR_N, (typ == 2'b10) ? 0 : 1);
    check("d_S2_IOR_N", IOR_N, (typ == 2'b01) ? 0 : 1);
    check("d_S2_MEMW_N", MEMW_N, 1);
    nextCycle();
    check("d_S3_IOR_N", IOR_N, (typ == 2'b01) ? 0 : 1);
    check("d_S3_MEMW_N", MEMW_N, (typ == 2'b01) ? 0 : 1);
    check("d_S3_IOW_N", IOW_N, (typ == 2'b10) ? 0 : 1);
    #1; DREQ = '0;
    nextCycle();
    check("d_S4_updA", updAddr, 1); check("d_S4_updW", updWc, 1);
    check("d_S4_DACK", DACK, 32'(1 << ch)); check("d_S4_IOR_N", IOR_N, 1);
    check("d_S4_EOP_N", EOP_N, tc ? 0 : 1); check("d_S4_intEOP", intEOP, tc ? 1 : 0);
    #1; HLDA = 1'b0; ctrlDisable = 1'b0;
    nextCycle();
    check("d_SI_HRQ", HRQ, 0); check("d_SI_upd", updAddr, 0);
    check("d_SI_EOP_N", EOP_N, 1); check("d_SI_DACK", DACK, 0);
  endtask

  task automatic doReset();
    #1; RESET_N = 1'b0; DREQ = '0; HLDA = 1'b0; ctrlDisable = 1'b0;
    nextCycle();
    #1; RESET_N = 1'b1;
  endtask

  int expOrder[5];

  initial begin
`ifdef ROTATING_PRIORITY_EN
    expOrder = '{0, 1, 2, 3, 0};
`else
    expOrder = '{0, 0, 0, 0, 0};
`endif
    nextCycle();
    check("r_HRQ", HRQ, 0); check("r_prog", programCondition, 1);
    check("r_EOP_N", EOP_N, 1); check("r_chan", activeChannel, 0);
    #1; RESET_N = 1'b1;
    nextCycle();

    xfer(0, 2'b10, 1'b0, 1'b0);
    xfer(2, 2'b01, 1'b0, 1'b0);
    xfer(3, 2'b00, 1'b0, 1'b0);
    xfer(1, 2'b10, 1'b1, 1'b0);
    xfer(1, 2'b01, 1'b0, 1'b1);

    // Priority order with all channels requesting.
    doReset();
    for (int g = 0; g < 5; g++) begin
      #1; DREQ = 4'hF; HLDA = 1'b0;
      nextCycle();
      #1; HLDA = 1'b1;
      nextCycle();
      check("p_order", activeChannel, 32'(expOrder[g]));
      nextCycle(); nextCycle(); nextCycle();
      #1; HLDA = 1'b0;
      nextCycle();
    end
    #1; DREQ = '0;
    nextCycle();

    // HLDA lost in S2: abort without write-back.
    doReset();
    #1; DREQ = 4'b0001; xferType = 8'h02; HLDA = 1'b0;
    nextCycle(); #1; HLDA = 1'b1;
    nextCycle(); nextCycle();
    #1; HLDA = 1'b0; DREQ = '0;
    nextCycle();
    check("a_DACK", DACK, 0); check("a_AEN", AEN, 0); check("a_upd", updAddr, 0);
    check("a_MEMR_N", MEMR_N, 1); check("a_HRQ", HRQ, 0);

    // Asynchronous reset in S3.
    #1; DREQ = 4'b1000; xferType = 8'h80; HLDA = 1'b0;
    nextCycle(); #1; HLDA = 1'b1;
    nextCycle(); nextCycle(); nextCycle();
    check("x_S3_MEMR_N", MEMR_N, 0);
    #2; RESET_N = 1'b0; #1;
    check("x_DACK", DACK, 0); check("x_MEMR_N", MEMR_N, 1); check("x_IOW_N", IOW_N, 1);
    check("x_HRQ", HRQ, 0); check("x_AEN", AEN, 0); check("x_upd", updWc, 0);
    DREQ = '0; HLDA = 1'b0;
    nextCycle(); #1; RESET_N = 1'b1;

    // Controller disabled blocks arbitration.
    #1; ctrlDisable = 1'b1; DREQ = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      check("c_HRQ", HRQ, 0); check("c_prog", programCondition, 1);
    end
    #1; ctrlDisable = 1'b0; DREQ = '0;
    nextCycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      #1;
      if ($urandom_range(3) == 0) DREQ = 4'($urandom);
      if ($urandom_range(15) == 0) xferType = 8'($urandom);
      ctrlDisable = ($urandom_range(7) == 0);
      tcReached   = $urandom_range(1);
      if (HRQ) HLDA = ($urandom_range(15) != 0);
      else     HLDA = ($urandom_range(7) == 0);
      if ($urandom_range(499) == 0) RESET_N = 1'b0;
      else RESET_N = 1'b1;
      nextCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
